// File: rtl/can_pkg.sv
// Shared CAN constants and the bit-stuffer state encoding.
package can_pkg;

   localparam int       STUFF_LIMIT   = 5;
   localparam logic     CAN_RECESSIVE = 1'b1;
   localparam logic     CAN_DOMINANT  = 1'b0;
   localparam int       CNT_W         = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS  = 2'd1,
      ST_STUFF = 2'd2
   } stuff_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/can_bitstuffer.sv
// CAN transmit bit stuffer: inserts a complement bit after five equal bits in the stuffing region.
// Optional bus monitor (rx_in vs. driven bit) enabled by defining CAN_BITSTUFF_MON_EN.
module can_bitstuffer
   import can_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             baud_tick,
   input  logic             tx_in,
   input  logic             stuff_en,
   input  logic             txing_in,
   input  logic             rx_in,
   output logic             can_tx,
   output logic             ch_st,
   output logic [CNT_W-1:0] stuff_cnt,
   output logic             bit_err
);

   stuff_state_e     state_q, state_d;
   logic             can_tx_q, can_tx_d;
   logic             ch_st_q, ch_st_d;
   logic [CNT_W-1:0] stuff_cnt_q, stuff_cnt_d;
   logic [2:0]       run_len_q, run_len_d;
   logic             last_bit_q, last_bit_d;
   logic             prev_en_q, prev_en_d;
   logic             stuff_cond;
   logic             frame_start;

   // The run is judged by the region flag of the bit that completed it, so a
   // stuff bit after the final CRC bit still goes out when stuff_en has dropped.
   assign stuff_cond  = (run_len_q == 3'(STUFF_LIMIT)) && prev_en_q;
   assign frame_start = baud_tick && txing_in && (state_q == ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (baud_tick) begin
         if (!txing_in) begin
            state_d = ST_IDLE;
         end else begin
            unique case (state_q)
               ST_IDLE:  state_d = ST_PASS;
               ST_PASS:  state_d = stuff_cond ? ST_STUFF : ST_PASS;
               ST_STUFF: state_d = ST_PASS;
               default:  state_d = ST_IDLE;
            endcase
         end
      end
   end

   // NOTE: every output of a combinational block gets a default first; a path
   // that leaves one unassigned would infer a latch.
   always_comb begin
      can_tx_d    = can_tx_q;
      ch_st_d     = ch_st_q;
      stuff_cnt_d = stuff_cnt_q;
      run_len_d   = run_len_q;
      last_bit_d  = last_bit_q;
      prev_en_d   = prev_en_q;
      if (baud_tick) begin
         if (!txing_in) begin
            can_tx_d   = CAN_RECESSIVE;
            ch_st_d    = 1'b0;
            run_len_d  = '0;
            last_bit_d = CAN_RECESSIVE;
            prev_en_d  = 1'b0;
         end else if (state_q != ST_IDLE && stuff_cond) begin
            // tx_in is left unconsumed; ch_st stalls the transmitter for this bit.
            can_tx_d    = ~last_bit_q;
            ch_st_d     = 1'b1;
            last_bit_d  = ~last_bit_q;
            run_len_d   = 3'd1;
            stuff_cnt_d = sat_inc(stuff_cnt_q);
         end else begin
            // The entry tick from IDLE already carries the first frame bit.
            can_tx_d   = tx_in;
            ch_st_d    = 1'b0;
            last_bit_d = tx_in;
            prev_en_d  = stuff_en;
            if (!stuff_en)
               run_len_d = '0;
            else if (tx_in == last_bit_q && prev_en_q)
               run_len_d = run_len_q + 3'd1;
            else
               run_len_d = 3'd1;
            if (frame_start) stuff_cnt_d = '0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         can_tx_q    <= CAN_RECESSIVE;
         ch_st_q     <= 1'b0;
         stuff_cnt_q <= '0;
         run_len_q   <= '0;
         last_bit_q  <= CAN_RECESSIVE;
         prev_en_q   <= 1'b0;
      end else begin
         can_tx_q    <= can_tx_d;
         ch_st_q     <= ch_st_d;
         stuff_cnt_q <= stuff_cnt_d;
         run_len_q   <= run_len_d;
         last_bit_q  <= last_bit_d;
         prev_en_q   <= prev_en_d;
      end
   end

`ifdef CAN_BITSTUFF_MON_EN
   logic bit_err_q, bit_err_d;

   // The bus read back at a tick belongs to the bit that is just ending.
   always_comb begin
      bit_err_d = bit_err_q;
      if (frame_start)
         bit_err_d = 1'b0;
      else if (baud_tick && state_q != ST_IDLE && rx_in != can_tx_q)
         bit_err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) bit_err_q <= 1'b0;
      else     bit_err_q <= bit_err_d;
   end

   assign bit_err = bit_err_q;
`else
   logic unused_rx_in;
   assign unused_rx_in = rx_in;
   assign bit_err      = 1'b0;
`endif

   assign can_tx    = can_tx_q;
   assign ch_st     = ch_st_q;
   assign stuff_cnt = stuff_cnt_q;

endmodule

// File: tb/tb_can_bitstuffer.sv
// Scoreboard bench for can_bitstuffer: directed bit sequences push expected outputs,
// a monitor pops and compares after every tick/reset edge and checks holding in between.
module tb_can_bitstuffer;

   logic       clk = 1'b0;
   logic       rst, baud_tick, tx_in, stuff_en, txing_in, rx_in;
   logic       can_tx, ch_st, bit_err;
   logic [6:0] stuff_cnt;

   typedef struct {
      logic       tx;
      logic       st;
      logic [6:0] cnt;
      logic       err;
      string      name;
   } exp_t;

   exp_t  sb_q[$];
   exp_t  last_exp;
   bit    have_last = 1'b0;
   int    n_checks  = 0;
   int    n_pass    = 0;
   logic  prev_tx;
   logic  exp_err;

`ifdef CAN_BITSTUFF_MON_EN
   localparam logic MON_BUILD = 1'b1;
`else
   localparam logic MON_BUILD = 1'b0;
`endif

   can_bitstuffer dut (
      .clk       (clk),
      .rst       (rst),
      .baud_tick (baud_tick),
      .tx_in     (tx_in),
      .stuff_en  (stuff_en),
      .txing_in  (txing_in),
      .rx_in     (rx_in),
      .can_tx    (can_tx),
      .ch_st     (ch_st),
      .stuff_cnt (stuff_cnt),
      .bit_err   (bit_err)
   );

   always #5 clk = ~clk;

   task automatic check(input exp_t e);
      n_checks++;
      if (can_tx === e.tx && ch_st === e.st && stuff_cnt === e.cnt && bit_err === e.err)
         n_pass++;
      else
         $display("FAIL %s @%0t: got can_tx=%b ch_st=%b stuff_cnt=%0d bit_err=%b, want can_tx=%b ch_st=%b stuff_cnt=%0d bit_err=%b",
                  e.name, $time, can_tx, ch_st, stuff_cnt, bit_err, e.tx, e.st, e.cnt, e.err);
   endtask

   // Monitor: an edge with baud_tick or rst produces a new expected output.
   initial begin
      forever begin
         logic ev;
         exp_t e;
         @(posedge clk);
         ev = baud_tick | rst;
         #1;
         if (ev) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               $display("FAIL scoreboard_underflow @%0t: DUT updated with no expected entry", $time);
            end else begin
               e = sb_q.pop_front();
               check(e);
               last_exp  = e;
               have_last = 1'b1;
            end
         end else if (have_last) begin
            e      = last_exp;
            e.name = {"hold_after_", last_exp.name};
            check(e);
         end
      end
   end

   task automatic bit_time(input logic tx, input logic en, input logic txing, input logic rx,
                           input logic etx, input logic est, input int ecnt, input logic eerr,
                           input string name);
      exp_t e;
      @(negedge clk);
      tx_in     = tx;
      stuff_en  = en;
      txing_in  = txing;
      rx_in     = rx;
      baud_tick = 1'b1;
      e.tx   = etx;
      e.st   = est;
      e.cnt  = 7'(ecnt);
      e.err  = eerr & MON_BUILD;
      e.name = name;
      sb_q.push_back(e);
      prev_tx = etx;
      @(negedge clk);
      baud_tick = 1'b0;
      @(negedge clk);
   endtask

   // Bus echoes the bit that was driven, so the monitor sees no mismatch.
   task automatic bit_std(input logic tx, input logic en, input logic txing,
                          input logic etx, input logic est, input int ecnt, input string name);
      bit_time(tx, en, txing, prev_tx, etx, est, ecnt, exp_err, name);
   endtask

   task automatic reset_dut(input string name);
      exp_t e;
      @(negedge clk);
      rst    = 1'b1;
      e.tx   = 1'b1;
      e.st   = 1'b0;
      e.cnt  = 7'd0;
      e.err  = 1'b0;
      e.name = name;
      sb_q.push_back(e);
      @(negedge clk);
      rst     = 1'b0;
      prev_tx = 1'b1;
      exp_err = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      baud_tick = 1'b0;
      tx_in     = 1'b1;
      stuff_en  = 1'b0;
      txing_in  = 1'b0;
      rx_in     = 1'b1;
      prev_tx   = 1'b1;
      exp_err   = 1'b0;

      reset_dut("reset");
      bit_std(1, 0, 0, 1, 0, 0, "idle_tick");

      // Five dominant bits from SOF, then a held recessive data bit.
      for (int i = 0; i < 5; i++) bit_std(0, 1, 1, 0, 0, 0, "zero_run");
      bit_std(1, 1, 1, 1, 1, 1, "stuff_one");
      bit_std(1, 1, 1, 1, 0, 1, "held_data");
      bit_std(0, 1, 1, 0, 0, 1, "after_stuff");
      bit_std(1, 0, 0, 1, 0, 1, "frame_end");

      // Alternating pattern never stuffs; entry clears the count.
      for (int i = 0; i < 64; i++) begin
         logic b;
         b = (i % 2 == 0);
         bit_std(b, 1, 1, b, 0, 0, "alternate");
      end
      bit_std(1, 0, 0, 1, 0, 0, "alt_end");

      // Five trailing CRC ones, stuff_en drops on the delimiter, then EOF/IFS.
      bit_std(0, 1, 1, 0, 0, 0, "crc_sof");
      for (int i = 0; i < 5; i++) bit_std(1, 1, 1, 1, 0, 0, "crc_ones");
      bit_std(1, 0, 1, 0, 1, 1, "trail_stuff");
      bit_std(1, 0, 1, 1, 0, 1, "delimiter");
      for (int i = 0; i < 11; i++) bit_std(1, 0, 1, 1, 0, 1, "eof_ones");
      bit_std(1, 0, 0, 1, 0, 1, "eof_end");

      // txing_in dropped while a stuff bit is on the bus.
      for (int i = 0; i < 5; i++) bit_std(0, 1, 1, 0, 0, 0, "abort_run");
      bit_std(1, 1, 1, 1, 1, 1, "abort_stuff");
      bit_std(1, 1, 0, 1, 0, 1, "abort_txing");
      bit_std(0, 1, 0, 1, 0, 1, "abort_idle");

      // Reset mid-STUFF, then reset mid-run: nothing further is stuffed.
      for (int i = 0; i < 5; i++) bit_std(0, 1, 1, 0, 0, 0, "rst_run");
      bit_std(1, 1, 1, 1, 1, 1, "rst_stuff");
      reset_dut("reset_mid_stuff");
      bit_std(1, 1, 0, 1, 0, 0, "post_reset_idle");
      for (int i = 0; i < 5; i++) bit_std(0, 1, 1, 0, 0, 0, "rst_run2");
      reset_dut("reset_mid_run");
      bit_std(0, 1, 1, 0, 0, 0, "post_reset_sof");
      for (int i = 0; i < 3; i++) bit_std(0, 1, 1, 0, 0, 0, "post_reset_run");
      bit_std(1, 0, 0, 1, 0, 0, "post_reset_end");

      // Bus pulled dominant while recessive is driven.
      bit_std(1, 0, 1, 1, 0, 0, "mon_entry");
      bit_time(1, 0, 1, 1'b0, 1, 0, 0, 1'b1, "mon_mismatch");
      exp_err = 1'b1;
      bit_std(1, 0, 1, 1, 0, 0, "mon_sticky");
      bit_std(1, 0, 0, 1, 0, 0, "mon_idle_sticky");
      exp_err = 1'b0;
      bit_std(0, 1, 1, 0, 0, 0, "mon_clear");
      bit_std(1, 0, 0, 1, 0, 0, "mon_end");

      for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(posedge clk);
      repeat (4) @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/can_bitstuffer.md
CAN_BITSTUFFER -- requirements
Module: can_bitstuffer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: baud_tick  input  1  one-clk strobe per CAN bit time; all bit-level updates occur only on clk edges where baud_tick=1.
REQ-004 SHALL have port: tx_in  input  1  unstuffed bit from the frame transmitter.
REQ-005 SHALL have port: stuff_en  input  1  transmitter's "bit is in stuffing region" flag (can_bitstuff).
REQ-006 SHALL have port: txing_in  input  1  transmitter frame-active flag.
REQ-007 SHALL have port: rx_in  input  1  sampled bus level (used only with monitor, REQ-024).
REQ-008 SHALL have port: can_tx  output  1  stuffed bit stream to the bus driver, registered.
REQ-009 SHALL have port: ch_st  output  1  stall to the transmitter; high for exactly the bit time of an inserted stuff bit.
REQ-010 SHALL have port: stuff_cnt  output  7  stuff bits inserted in the current/last frame, saturating at 127.
REQ-011 SHALL have port: bit_err  output  1  sticky bus-mismatch flag.

Function
REQ-012 SHALL implement FSM states IDLE, PASS, STUFF; transitions evaluated only when baud_tick=1.
REQ-013 IDLE: can_tx=1 (recessive), ch_st=0, run_len=0; on tick with txing_in=1 -> PASS, clearing stuff_cnt and bit_err in the same cycle.
REQ-014 PASS, tick, no stuff condition: can_tx<=tx_in; last_bit<=tx_in; prev_en<=stuff_en; run_len<=(stuff_en and tx_in==last_bit and prev_en) ? run_len+1 : 1 when stuff_en, else 0.
REQ-015 Stuff condition SHALL be: run_len==5 and prev_en==1 (stuffing-region flag of the bit completing the run, not the current stuff_en), so a trailing stuff bit after the last CRC bit is still inserted.
REQ-016 PASS, tick, stuff condition true: can_tx<=~last_bit, ch_st<=1, last_bit<=~last_bit, run_len<=1, stuff_cnt+1 (saturating), -> STUFF; tx_in is not consumed.
REQ-017 STUFF, tick: ch_st<=0 and tx_in handled exactly per REQ-014/015 (the stuff bit counts as run length 1), -> PASS; back-to-back stuff bits are thus impossible without 4 further equal bits.
REQ-018 Any tick with txing_in=0 SHALL force IDLE outputs (REQ-013) regardless of state, including mid-STUFF; stuff_cnt holds its value.
REQ-019 Latency: can_tx SHALL reflect tx_in one clk after the baud_tick edge that samples it; no combinational path from inputs to outputs.
REQ-020 Between ticks all outputs and internal registers SHALL hold.
REQ-021 run_len SHALL be 3 bits and never exceed 5.

Reset
REQ-022 rst=1 SHALL, on the next clk edge, set state=IDLE, can_tx=1, ch_st=0, stuff_cnt=0, bit_err=0, run_len=0, last_bit=1, prev_en=0; rst has priority over baud_tick.
REQ-023 Reset asserted mid-frame or mid-STUFF SHALL abort with no further stuff bit emitted.

Configuration
REQ-024 With CAN_BITSTUFF_MON_EN defined: on each tick in PASS/STUFF, rx_in is compared with the can_tx value driven during the ending bit; mismatch sets bit_err (sticky until frame start or reset).
REQ-025 Without CAN_BITSTUFF_MON_EN: bit_err SHALL be constant 0, rx_in ignored, no compare logic synthesized; all ports remain present.

Structure
REQ-026 Shared package can_pkg SHALL hold: STUFF_LIMIT=5, CAN_RECESSIVE=1, CAN_DOMINANT=0, stuffer state encoding.
REQ-027 Block SHALL be flat; no sub-module.

Verification
REQ-028 tx_in=0 x5 with stuff_en=1 from SOF -> 6th bit time can_tx=1, ch_st=1 for one bit, then held data bit emitted; stuff_cnt=1.
REQ-029 Alternating 1010... for 64 bits, stuff_en=1 -> no stuff bits, ch_st never high, stuff_cnt=0.
REQ-030 Last 5 CRC bits =1 with stuff_en dropping on the following bit (delimiter) -> stuff bit 0 inserted before delimiter; stuff_cnt incremented.
REQ-031 Eleven 1s with stuff_en=0 (EOF/IFS) -> no stuffing, can_tx=1 throughout.
REQ-032 txing_in driven 0 during STUFF, and separately rst pulsed mid-frame -> next edge can_tx=1, ch_st=0, IDLE; stuff_cnt holds (txing case) / 0 (rst case).
REQ-033 MON_EN build: rx_in forced 0 while can_tx=1 for one bit -> bit_err=1, stays 1 until next frame start; non-MON build: bit_err=0 throughout.
